// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed byte stream -> instruction memory word writes with XOR check
// Holds the core in reset until a frame with a valid length and matching checksum has been written.
module imem_loader #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

    state_t      state;
    logic [7:0]  len_lo;
    logic [7:0]  csum;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [15:0] hdr_len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        fire;

    assign fire    = byte_valid & byte_ready;
    assign hdr_len = {byte_data, len_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'd0;
            len_lo     <= 8'd0;
            len        <= 16'd0;
            csum       <= 8'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= HDR0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        core_rst   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        error_code <= 2'd0;
                        csum       <= 8'd0;
                        word_idx   <= 16'd0;
                        byte_idx   <= 2'd0;
                    end
                end
                HDR0: begin
                    if (fire) begin
                        len_lo <= byte_data;
                        csum   <= csum ^ byte_data;
                        state  <= HDR1;
                    end
                end
                HDR1: begin
                    if (fire) begin
                        csum <= csum ^ byte_data;
                        len  <= hdr_len;
                        if (hdr_len == 16'd0 || hdr_len > MAX_LEN) begin
                            state      <= ERR;
                            error      <= 1'b1;
                            error_code <= 2'd1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (fire) begin
                        csum     <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                // Byte 3 completes the word; the write strobe lands in the next cycle.
                                imem_we    <= 1'b1;
                                imem_addr  <= {14'd0, word_idx, 2'b00};
                                imem_wdata <= {byte_data, word_buf};
                                word_idx   <= word_idx + 16'd1;
                                if (word_idx == len - 16'd1) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (fire) begin
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state      <= ERR;
                            error      <= 1'b1;
                            error_code <= 2'd2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized frames and byte gaps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    imem_loader #(.MEM_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .error(error),
        .error_code(error_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_st[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic stat_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes on every strobe cycle, expected status on done/error rising.
    always @(negedge clk) begin
        wr_t w;
        int  code;
        if (imem_we) begin
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("imem_addr", imem_addr, w.addr);
                chk("imem_wdata", imem_wdata, w.data);
            end
        end
        if ((done | error) && !stat_prev && !rst) begin
            chk("status_expected", 32'(exp_st.size() != 0), 32'd1);
            if (exp_st.size() != 0) begin
                code = exp_st.pop_front();
                chk("done", 32'(done), 32'(code == 0));
                chk("error", 32'(error), 32'(code != 0));
                chk("error_code", 32'(error_code), 32'(code));
                chk("core_rst", 32'(core_rst), 32'(code != 0));
                chk("byte_ready_end", 32'(byte_ready), 32'd0);
                chk("busy_end", 32'(busy), 32'd0);
                chk("writes_before_status", 32'(exp_wr.size()), 32'd0);
            end
        end
        stat_prev = done | error;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gmax, input logic st);
        int g;
        int guard;
        g = $urandom_range(gmax, 0);
        guard = 0;
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        if (st) start = 1'b1;
        while (!byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!byte_ready) begin
            chk("byte_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic wait_status();
        int guard;
        guard = 0;
        while (exp_st.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_st.size() != 0) begin
            chk("status_timeout", 32'd0, 32'd1);
            exp_st.delete();
        end
    endtask

    // Reference: frame = len_lo, len_hi, words LSB first, XOR of all preceding bytes.
    task automatic run_frame(input int n, input logic [31:0] ws[$], input logic bad_csum,
                             input int gmax, input logic mid_start, input int rst_after);
        logic [7:0] data[$];
        logic [7:0] x;
        logic       len_ok;
        wr_t        w;
        len_ok = (n >= 1 && n <= 64);
        x = 8'(n) ^ 8'(n >> 8);
        for (int i = 0; i < ws.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                data.push_back(8'(ws[i] >> (8 * k)));
                x = x ^ 8'(ws[i] >> (8 * k));
            end
            if (len_ok && (rst_after < 0 || (i + 1) * 4 <= rst_after)) begin
                w.addr = 32'(i * 4);
                w.data = ws[i];
                exp_wr.push_back(w);
            end
        end
        if (!len_ok) exp_st.push_back(1);
        do_start();
        send_byte(8'(n), gmax, 1'b0);
        send_byte(8'(n >> 8), gmax, 1'b0);
        if (!len_ok) begin
            wait_status();
            @(negedge clk);
            chk("byte_ready_after_len_err", 32'(byte_ready), 32'd0);
            return;
        end
        for (int k = 0; k < data.size(); k++) begin
            if (rst_after >= 0 && k == rst_after) break;
            send_byte(data[k], gmax, mid_start && k == 5);
        end
        if (rst_after >= 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            chk("writes_pending_after_rst", 32'(exp_wr.size()), 32'd0);
            chk("busy_after_rst", 32'(busy), 32'd0);
            chk("core_rst_after_rst", 32'(core_rst), 32'd1);
            chk("byte_ready_after_rst", 32'(byte_ready), 32'd0);
            return;
        end
        exp_st.push_back(bad_csum ? 2 : 0);
        send_byte(bad_csum ? (x ^ 8'h01) : x, gmax, 1'b0);
        wait_status();
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] none[$];
        logic [31:0] rnd[$];
        int          n;
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_error_code", 32'(error_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;

        ws = '{32'h00500093, 32'h00100113};
        run_frame(2, ws, 1'b0, 0, 1'b0, -1);
        run_frame(2, ws, 1'b1, 0, 1'b0, -1);
        run_frame(0, none, 1'b0, 0, 1'b0, -1);
        run_frame(65, none, 1'b0, 0, 1'b0, -1);
        run_frame(2, ws, 1'b0, 3, 1'b0, -1);

        rnd = '{$urandom, $urandom};
        run_frame(2, rnd, 1'b0, 1, 1'b0, 5);
        run_frame(2, ws, 1'b0, 0, 1'b0, -1);

        rnd = '{$urandom, $urandom, $urandom};
        run_frame(3, rnd, 1'b0, 2, 1'b1, -1);

        for (int f = 0; f < 5; f++) begin
            rnd.delete();
            n = (f == 0) ? 64 : (f == 1) ? 1 : int'($urandom_range(64, 1));
            for (int i = 0; i < n; i++) rnd.push_back($urandom);
            run_frame(n, rnd, 1'($urandom_range(1, 0)), 3, 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        chk("writes_left", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
